// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg: RV32I opcode constants, instruction formats and the decoded field tuple
// shared by the instruction encoder/writer.
package rv_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL} fmt_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [1:0]  func7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } fields_t;

    function automatic fmt_t fmt_of(input logic [6:0] op);
        fmt_of = FMT_ILL;
        case (op)
            OP_R:                             fmt_of = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYS: fmt_of = FMT_I;
            OP_STORE:                         fmt_of = FMT_S;
            OP_BRANCH:                        fmt_of = FMT_B;
            OP_LUI, OP_AUIPC:                 fmt_of = FMT_U;
            OP_JAL:                           fmt_of = FMT_J;
            default:                          fmt_of = FMT_ILL;
        endcase
    endfunction

endpackage

// File: rtl/inst_pack.sv
// inst_pack: combinational packer turning a decoded RV32I field tuple into a 32-bit
// instruction word, flagging opcodes that have no supported format.
module inst_pack
    import rv_enc_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] inst,
    output logic        illegal
);

    fmt_t fmt;
    logic shift;

    assign fmt     = fmt_of(f.opcode);
    assign illegal = fmt == FMT_ILL;
    // slli/srli/srai carry shamt in the rs2 slot and the arithmetic bit in inst[30]
    assign shift   = f.opcode == OP_IMM && f.func3[1:0] == 2'b01;

    always_comb begin
        inst = '0;
        case (fmt)
            FMT_R: inst = {1'b0, f.func7[1], 4'b0, f.func7[0], f.rs2, f.rs1, f.func3, f.rd, f.opcode};
            FMT_I: inst = shift ? {1'b0, f.func7[1], 5'b0, f.imm[4:0], f.rs1, f.func3, f.rd, f.opcode}
                                : {f.imm[11:0], f.rs1, f.func3, f.rd, f.opcode};
            FMT_S: inst = {f.imm[11:5], f.rs2, f.rs1, f.func3, f.imm[4:0], f.opcode};
            FMT_B: inst = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.func3, f.imm[4:1], f.imm[11], f.opcode};
            FMT_U: inst = {f.imm[31:12], f.rd, f.opcode};
            FMT_J: inst = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            default: inst = '0;
        endcase
    end

endmodule

// File: rtl/inst_encoder_writer.sv
// inst_encoder_writer: encodes RV32I field tuples, queues the words in a small FIFO and
// writes them to consecutive instruction-memory word addresses.
module inst_encoder_writer
    import rv_enc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_func3,
    input  logic [1:0]        in_func7,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    output logic              im_wr_valid,
    input  logic              im_wr_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_di,
    output logic [3:0]        im_web,
    output logic [ADDR_W:0]   wr_count,
    output logic              illegal_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] CNT_MAX = '1;

    fields_t     f;
    logic [31:0] inst;
    logic [31:0] last_di;
    logic [31:0] mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        illegal, full, empty, accept, push, pop;

    assign f = {in_opcode, in_func3, in_func7, in_rs1, in_rs2, in_rd, in_imm};

    inst_pack u_pack (
        .f       (f),
        .inst    (inst),
        .illegal (illegal)
    );

    assign empty       = wr_ptr == rd_ptr;
    assign full        = wr_ptr[PW-1:0] == rd_ptr[PW-1:0] && wr_ptr[PW] != rd_ptr[PW];
    assign in_ready    = !rst && !full && !flush;
    assign accept      = in_valid && in_ready;
    assign push        = accept && !illegal;
    assign im_wr_valid = !empty;
    assign pop         = im_wr_valid && im_wr_ready && !flush;
    // when the FIFO drains, keep showing the last word presented
    assign im_di       = empty ? last_di : mem[rd_ptr[PW-1:0]];
    assign im_web      = im_wr_valid ? 4'b0000 : 4'b1111;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            im_addr     <= ADDR_W'(BASE_ADDR);
            wr_count    <= '0;
            illegal_err <= 1'b0;
            last_di     <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            im_addr     <= ADDR_W'(BASE_ADDR);
            wr_count    <= '0;
            illegal_err <= 1'b0;
            last_di     <= im_di;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                im_addr  <= im_addr + 1'b1;
                wr_count <= wr_count == CNT_MAX ? wr_count : wr_count + 1'b1;
                last_di  <= im_di;
            end
            if (accept && illegal)
                illegal_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PW-1:0]] <= inst;
    end

endmodule

// File: tb/tb_inst_encoder_writer.sv
// tb_inst_encoder_writer: directed and random stimulus against a queue-based model;
// a second instance with ADDR_W=2 exercises address wrap and count saturation.
module tb_inst_encoder_writer;

    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, im_wr_ready = 0;
    logic [6:0]  in_opcode = 0;
    logic [2:0]  in_func3 = 0;
    logic [1:0]  in_func7 = 0;
    logic [4:0]  in_rs1 = 0, in_rs2 = 0, in_rd = 0;
    logic [31:0] in_imm = 0;

    logic        in_ready, im_wr_valid, illegal_err;
    logic [13:0] im_addr;
    logic [31:0] im_di;
    logic [3:0]  im_web;
    logic [14:0] wr_count;

    logic        in_ready_b, im_wr_valid_b, illegal_err_b;
    logic [1:0]  im_addr_b;
    logic [31:0] im_di_b;
    logic [3:0]  im_web_b;
    logic [2:0]  wr_count_b;

    inst_encoder_writer dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .im_wr_valid(im_wr_valid),
        .im_wr_ready(im_wr_ready), .im_addr(im_addr), .im_di(im_di), .im_web(im_web),
        .wr_count(wr_count), .illegal_err(illegal_err)
    );

    inst_encoder_writer #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .im_wr_valid(im_wr_valid_b),
        .im_wr_ready(im_wr_ready), .im_addr(im_addr_b), .im_di(im_di_b), .im_web(im_web_b),
        .wr_count(wr_count_b), .illegal_err(illegal_err_b)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [31:0] q[$];
    int          addr = 0, cnt = 0;
    bit          err = 0, accepted = 0;
    logic [31:0] last_di = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // field placement written as plain shifts/masks of the tuple; bit 32 flags an unsupported opcode
    function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [2:0] f3,
        input logic [1:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] rd, input logic [31:0] imm);
        logic [31:0] o, d, s1, s2, fn, base;
        o = 32'(op); d = 32'(rd) << 7; fn = 32'(f3) << 12; s1 = 32'(rs1) << 15; s2 = 32'(rs2) << 20;
        base = o | d | fn | s1;
        case (op)
            7'h33: return {1'b0, base | s2 | (32'(f7[1]) << 30) | (32'(f7[0]) << 25)};
            7'h13, 7'h03, 7'h67, 7'h73:
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))
                    return {1'b0, base | ((imm & 32'h1F) << 20) | (32'(f7[1]) << 30)};
                else
                    return {1'b0, base | ((imm & 32'hFFF) << 20)};
            7'h23: return {1'b0, o | ((imm & 32'h1F) << 7) | fn | s1 | s2 | (((imm >> 5) & 32'h7F) << 25)};
            7'h63: return {1'b0, o | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8) | fn | s1 | s2
                                 | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 1) << 31)};
            7'h37, 7'h17: return {1'b0, o | d | (imm & 32'hFFFFF000)};
            7'h6F: return {1'b0, o | d | (imm & 32'h000FF000) | (((imm >> 11) & 1) << 20)
                                 | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 1) << 31)};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic check_all();
        chk("in_ready", in_ready, !rst && q.size() < 4 && !flush);
        chk("in_ready_b", in_ready_b, !rst && q.size() < 4 && !flush);
        chk("wr_valid", im_wr_valid, q.size() > 0);
        chk("web", im_web, q.size() > 0 ? 4'b0000 : 4'b1111);
        chk("di", im_di, q.size() > 0 ? q[0] : last_di);
        chk("di_b", im_di_b, q.size() > 0 ? q[0] : last_di);
        chk("addr", im_addr, addr % 16384);
        chk("addr_b", im_addr_b, addr % 4);
        chk("count", wr_count, cnt > 32767 ? 32767 : cnt);
        chk("count_b", wr_count_b, cnt > 7 ? 7 : cnt);
        chk("illegal_err", illegal_err, err);
        if (q.size() > 0) last_di = q[0];
    endtask

    task automatic model_reset();
        q.delete(); addr = 0; cnt = 0; err = 0; last_di = 0;
    endtask

    task automatic step();
        bit acc, wr;
        logic [32:0] e;
        acc = in_valid && q.size() < 4 && !flush && !rst;
        wr = q.size() > 0 && im_wr_ready && !flush;
        e = ref_enc(in_opcode, in_func3, in_func7, in_rs1, in_rs2, in_rd, in_imm);
        @(posedge clk);
        if (flush) begin
            q.delete(); addr = 0; cnt = 0; err = 0;
        end else begin
            if (wr) begin void'(q.pop_front()); addr++; cnt++; end
            if (acc) begin
                if (e[32]) err = 1;
                else q.push_back(e[31:0]);
            end
        end
        accepted = acc;
        #1 check_all();
    endtask

    task automatic set_tuple(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] f7,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
        in_opcode = op; in_func3 = f3; in_func7 = f7; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm;
    endtask

    task automatic push_one();
        int n = 0;
        in_valid = 1;
        do begin step(); n++; end while (!accepted && n < 20);
        in_valid = 0;
        chk("accept_bound", accepted, 1);
    endtask

    task automatic drain();
        int n = 0;
        im_wr_ready = 1;
        while (q.size() > 0 && n < 50) begin step(); n++; end
        chk("drained", im_wr_valid, 0);
    endtask

    task automatic do_flush();
        flush = 1;
        step();
        flush = 0;
    endtask

    localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst = 0;
        #1 check_all();

        // single add with the IM ready
        im_wr_ready = 1;
        set_tuple(7'h33, 3'd0, 2'b00, 5'd1, 5'd2, 5'd3, 32'd0);
        push_one();
        chk("add_di", im_di, 32'h002081B3);
        chk("add_addr", im_addr, 0);
        step();
        chk("add_count", wr_count, 1);

        // back-to-back stream
        do_flush();
        set_tuple(7'h33, 3'd0, 2'b10, 5'd1, 5'd2, 5'd3, 32'd0);
        push_one();
        chk("sub_di", im_di, 32'h402081B3);
        set_tuple(7'h63, 3'd0, 2'b00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC);
        push_one();
        chk("beq_di", im_di, 32'hFE208EE3);
        chk("beq_addr", im_addr, 1);
        set_tuple(7'h6F, 3'd0, 2'b00, 5'd0, 5'd0, 5'd1, 32'd8);
        push_one();
        chk("jal_di", im_di, 32'h008000EF);
        set_tuple(7'h37, 3'd0, 2'b00, 5'd0, 5'd0, 5'd5, 32'h12345000);
        push_one();
        chk("lui_di", im_di, 32'h123452B7);
        chk("lui_addr", im_addr, 3);
        drain();

        // fill the FIFO with the IM stalled
        do_flush();
        im_wr_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_tuple(7'h13, 3'd0, 2'b00, 5'(i), 5'd0, 5'(i + 1), 32'(i * 3));
            push_one();
        end
        chk("full_ready", in_ready, 0);
        set_tuple(7'h13, 3'd0, 2'b00, 5'd9, 5'd0, 5'd9, 32'd77);
        in_valid = 1;
        step();
        chk("held_fifth", accepted, 0);
        im_wr_ready = 1;
        step();
        chk("full_pop_no_bypass", accepted, 0);
        push_one();
        drain();
        chk("five_count", wr_count, 5);
        chk("wrap_addr_b", im_addr_b, 1);
        chk("wrap_count_b", wr_count_b, 5);

        // unsupported opcode
        do_flush();
        set_tuple(7'h7F, 3'd0, 2'b00, 5'd1, 5'd2, 5'd3, 32'd0);
        push_one();
        chk("ill_err", illegal_err, 1);
        chk("ill_novalid", im_wr_valid, 0);
        set_tuple(7'h33, 3'd0, 2'b00, 5'd1, 5'd2, 5'd3, 32'd0);
        push_one();
        chk("after_ill_di", im_di, 32'h002081B3);
        chk("after_ill_addr", im_addr, 0);
        do_flush();
        chk("flush_err", illegal_err, 0);

        // flush with words queued and a ready IM
        im_wr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_tuple(7'h37, 3'd0, 2'b00, 5'd0, 5'd0, 5'(i), 32'($urandom));
            push_one();
        end
        im_wr_ready = 1;
        do_flush();
        chk("flush_valid", im_wr_valid, 0);
        chk("flush_addr", im_addr, 0);
        chk("flush_count", wr_count, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            set_tuple(($urandom % 12 == 0) ? 7'(32'h7F & $urandom) : OPS[$urandom % 10],
                      3'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                      ($urandom % 2) ? $urandom : 32'(-$urandom_range(0, 4096)));
            in_valid = ($urandom % 3) != 0;
            im_wr_ready = ($urandom % 4) != 0;
            flush = ($urandom % 60) == 0;
            step();
        end
        flush = 0;
        in_valid = 0;

        // asynchronous reset with words pending
        im_wr_ready = 0;
        for (int i = 0; i < 2; i++) begin
            set_tuple(7'h33, 3'd0, 2'b01, 5'd4, 5'd5, 5'd6, 32'd0);
            push_one();
        end
        #3 rst = 1;
        #1 model_reset();
        check_all();
        chk("arst_valid", im_wr_valid, 0);
        chk("arst_di", im_di, 0);
        @(negedge clk) rst = 0;
        #1 check_all();
        im_wr_ready = 1;
        set_tuple(7'h23, 3'd2, 2'b00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8);
        push_one();
        chk("post_rst_addr", im_addr, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
